// File: rtl/seq_add_32_pkg.sv
// Shared constants for the sequential byte-sliced adder: slice width and
// sequencer state encodings.
package seq_add_32_pkg;

   localparam int SLICE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : seq_add_32_pkg

// File: rtl/block_add_8.sv
// 8-bit carry-lookahead adder slice. Produces the sum, the rippled carry out
// and a group-lookahead carry out (cout_fast); both carries are equal.
module block_add_8
   import seq_add_32_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout,
   output logic               cout_fast
);

   logic [SLICE_W-1:0] g_s;
   logic [SLICE_W-1:0] p_s;
   logic [SLICE_W:0]   c_s;
   logic               gg_s;
   logic               gp_s;

   // Per-bit generate/propagate, carry chain, and group generate/propagate.
   always_comb begin
      g_s    = a & b;
      p_s    = a ^ b;
      c_s    = '0;
      c_s[0] = cin;
      for (int i = 0; i < SLICE_W; i++) begin
         c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
      end
      sum  = p_s ^ c_s[SLICE_W-1:0];
      cout = c_s[SLICE_W];

      gg_s = 1'b0;
      gp_s = 1'b1;
      for (int i = 0; i < SLICE_W; i++) begin
         gg_s = g_s[i] | (p_s[i] & gg_s);
         gp_s = gp_s & p_s[i];
      end
      cout_fast = gg_s | (gp_s & cin);
   end

endmodule : block_add_8

// File: rtl/seq_add_32.sv
// Multi-cycle add/subtract sequencer: one 8-bit adder slice is reused across
// all byte positions, least-significant byte first, with the carry held in a
// register between cycles. Start/done handshake, latched result and flags.
module seq_add_32
   import seq_add_32_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / SLICE_W;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   state_e             state_q,  state_d;
   logic [KW-1:0]      k_q,      k_d;
   logic [WIDTH-1:0]   opa_q,    opa_d;
   logic [WIDTH-1:0]   opb_q,    opb_d;
   logic               carry_q,  carry_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q,   cout_d;
   logic               ovf_q,    ovf_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;

   int                 slice_lo_s;
   logic [SLICE_W-1:0] slice_a_s;
   logic [SLICE_W-1:0] slice_b_s;
   logic [SLICE_W-1:0] slice_sum_s;
   logic               slice_cout_s;
   logic               slice_cout_fast_s;
   logic               accept_s;

   // Select the byte of each latched operand addressed by the slice index.
   always_comb begin
      slice_lo_s = int'(k_q) * SLICE_W;
      slice_a_s  = opa_q[slice_lo_s +: SLICE_W];
      slice_b_s  = opb_q[slice_lo_s +: SLICE_W];
   end

   block_add_8 u_slice (
      .a         (slice_a_s),
      .b         (slice_b_s),
      .cin       (carry_q),
      .sum       (slice_sum_s),
      .cout      (slice_cout_s),
      .cout_fast (slice_cout_fast_s)
   );

   // A new request is taken only when no operation is in flight.
   always_comb begin
      accept_s = start && ((state_q == IDLE) || (state_q == DONE));
   end

   // Next-state, slice commit, operand capture and output flag computation.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      busy_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            result_d[slice_lo_s +: SLICE_W] = slice_sum_s;
            carry_d = slice_cout_s;
            k_d     = k_q + KW'(1);
            if (k_q == K_LAST) begin
               // The lookahead carry equals the rippled one; it feeds the flag.
               cout_d  = slice_cout_fast_s;
               ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                         (slice_sum_s[SLICE_W-1] != opa_q[WIDTH-1]);
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            if (accept_s) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Subtraction is a + ~b + 1: invert b here, inject the 1 as carry-in.
      if (accept_s) begin
         opa_d   = a;
         opb_d   = sub ? ~b : b;
         carry_d = sub;
         k_d     = '0;
      end else begin
         opa_d   = opa_q;
         opb_d   = opb_q;
      end

      busy_d = (state_d == RUN);
   end

   // State and datapath registers with synchronous clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule : seq_add_32

// File: tb/tb_seq_add_32.sv
// Scoreboard bench for seq_add_32: the driver queues expected responses as it
// issues requests; a monitor pops and compares on every done pulse.
module tb_seq_add_32;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        sub;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        cout;
   logic        overflow;

   typedef struct {
      logic [31:0] res;
      logic        co;
      logic        ov;
      int          due;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   busy_cnt = 0;

   seq_add_32 #(.WIDTH(32)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Monitor: on each done pulse pop the oldest expectation and compare.
   always @(negedge clock) begin : mon
      exp_t e;
      if (reset) begin
         busy_cnt = 0;
      end else if (done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check({e.tag, "_result"},   result,              e.res);
            check({e.tag, "_cout"},     {31'd0, cout},       {31'd0, e.co});
            check({e.tag, "_overflow"}, {31'd0, overflow},   {31'd0, e.ov});
            check({e.tag, "_latency"},  32'(cyc),            32'(e.due));
            check({e.tag, "_busy_len"}, 32'(busy_cnt),       32'd4);
         end
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt++;
      end
   end

   // Present a request at a negedge; expect done 5 cycles later.
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        input logic [31:0] er, input logic eco, input logic eov,
                        input string tag);
      exp_t e;
      a     = ia;
      b     = ib;
      sub   = isub;
      start = 1'b1;
      e.res = er;
      e.co  = eco;
      e.ov  = eov;
      e.due = cyc + 5;
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Wait (bounded) until the negedge on which done is seen.
   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         if (done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic [31:0] er, input logic eco, input logic eov,
                         input string tag);
      issue(ia, ib, isub, er, eco, eov, tag);
      wait_done(tag);
      @(negedge clock);
   endtask

   initial begin : stim
      logic [31:0]        ra, rb, rr;
      logic               rs, rco, rov;
      logic [32:0]        usum;
      logic signed [32:0] ssum;

      reset = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(negedge clock);
      check("rst_result",   result,              32'd0);
      check("rst_cout",     {31'd0, cout},       32'd0);
      check("rst_overflow", {31'd0, overflow},   32'd0);
      check("rst_busy",     {31'd0, busy},       32'd0);
      check("rst_done",     {31'd0, done},       32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Directed vectors.
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "byte_carry");
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "full_ripple");
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf");
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
      run_op(32'h0000_0009, 32'h0000_0009, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_zero");

      // Start during RUN is ignored; operand changes after acceptance are harmless.
      issue(32'h0000_1234, 32'h0000_4321, 1'b0, 32'h0000_5555, 1'b0, 1'b0, "ignore_run");
      @(negedge clock);
      @(negedge clock);
      start = 1'b1;
      a     = 32'hFFFF_FFFF;
      b     = 32'hFFFF_FFFF;
      sub   = 1'b1;
      @(negedge clock);
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0BAD_F00D;
      wait_done("ignore_run");
      @(negedge clock);

      // Back-to-back: second start presented in the DONE cycle.
      issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, "b2b_1");
      wait_done("b2b_1");
      issue(32'h0000_0020, 32'h0000_0010, 1'b1, 32'h0000_0010, 1'b1, 1'b0, "b2b_2");
      wait_done("b2b_2");
      @(negedge clock);

      // Reset after slice 1 commits: operation abandoned, no done.
      a     = 32'hAAAA_AAAA;
      b     = 32'h5555_5555;
      sub   = 1'b0;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      start = 1'b1;
      a     = 32'h0000_0001;
      b     = 32'h0000_0001;
      @(negedge clock);
      check("midrst_result",   result,            32'd0);
      check("midrst_cout",     {31'd0, cout},     32'd0);
      check("midrst_overflow", {31'd0, overflow}, 32'd0);
      check("midrst_busy",     {31'd0, busy},     32'd0);
      check("midrst_done",     {31'd0, done},     32'd0);
      reset = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clock);
      check("midrst_idle_busy", {31'd0, busy}, 32'd0);
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "post_rst");

      // Random operations against a 33-bit reference model.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (rs) begin
            rr   = ra - rb;
            rco  = (ra >= rb);
            ssum = $signed({ra[31], ra}) - $signed({rb[31], rb});
         end else begin
            usum = {1'b0, ra} + {1'b0, rb};
            rr   = usum[31:0];
            rco  = usum[32];
            ssum = $signed({ra[31], ra}) + $signed({rb[31], rb});
         end
         rov = ssum[32] ^ ssum[31];
         issue(ra, rb, rs, rr, rco, rov, "rand");
         wait_done("rand");
         if ((i % 3) != 0) @(negedge clock);
      end

      repeat (4) @(negedge clock);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seq_add_32
